// File: rtl/nn_pkg.sv
// nn_pkg: shared definitions for the time-multiplexed perceptron layer.
//   - nn_state_e        : sequencer states (IDLE, MAC, CMP, DONE)
//   - bias_ofs/th_ofs   : slot offsets of bias and threshold inside a neuron block
//   - slots_per_neuron  : size of one neuron block in the parameter store
//   - acc_w_ok          : accumulator width check (no-overflow guarantee)
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } nn_state_e;

  // Neuron block layout: w[0..N_INPUTS-1], bias, threshold.
  function automatic int bias_ofs(input int n_inputs);
    return n_inputs;
  endfunction

  function automatic int th_ofs(input int n_inputs);
    return n_inputs + 1;
  endfunction

  function automatic int slots_per_neuron(input int n_inputs);
    return n_inputs + 2;
  endfunction

  // N products of 2*DATA_W bits plus a DATA_W bias cannot overflow this width.
  function automatic bit acc_w_ok(input int acc_w, input int data_w, input int n_inputs);
    return acc_w >= (2 * data_w + $clog2(n_inputs + 1));
  endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// nn_mac_unit: signed DATA_W x DATA_W multiply into an ACC_W accumulator.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   load         : acc <= sext(load_val) (bias preload, has priority)
//   load_val     : signed preload value
//   acc_en       : acc <= acc + a*b
//   a, b         : signed multiplicands
//   acc          : signed accumulator
module nn_mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] load_val,
  input  logic                     acc_en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (load) begin
      acc <= ACC_W'(load_val);
    end else if (acc_en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/nn_layer_seq.sv
// nn_layer_seq: time-multiplexed perceptron layer, one shared MAC per cycle.
// Build option: define NN_RELU_OUT_EN to report max(0, acc - threshold)
// (saturated) on out_value instead of the fire bit.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   cfg_valid/cfg_data   : byte-serial parameter load into the next slot
//   cfg_clear            : rewind parameter pointer (a same-cycle write goes to slot 0)
//   in_valid/in_data     : serial input sample load into the next input slot
//   start                : begin an evaluation (accepted in IDLE or DONE)
//   busy, done           : in progress / one-cycle completion pulse
//   out_valid            : results valid until the next accepted start
//   out_fire             : per-neuron step outputs
//   out_sel/out_value    : per-neuron activation readback (0 if out_sel out of range)
//   cfg_err              : sticky, a load was attempted while busy
//
// state | meaning
// IDLE  | waiting for start, loads accepted
// MAC   | accumulate in[k]*w[n][k], one product per cycle
// CMP   | compare acc with threshold[n], store fire/value, preload next bias
// DONE  | done pulse, loads and start accepted
module nn_layer_seq
  import nn_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int N_INPUTS  = 4,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 20,
  localparam int NW       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_valid,
  input  logic signed [DATA_W-1:0] cfg_data,
  input  logic                     cfg_clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     out_valid,
  output logic [N_NEURONS-1:0]     out_fire,
  input  logic [NW-1:0]            out_sel,
  output logic [DATA_W-1:0]        out_value,
  output logic                     cfg_err
);

  localparam int SPN      = slots_per_neuron(N_INPUTS);
  localparam int BIAS_OFS = bias_ofs(N_INPUTS);
  localparam int TH_OFS   = th_ofs(N_INPUTS);
  localparam int N_SLOTS  = N_NEURONS * SPN;
  localparam int SW       = $clog2(N_SLOTS);
  localparam int KW       = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  if (!acc_w_ok(ACC_W, DATA_W, N_INPUTS)) begin : g_acc_w_chk
    $error("nn_layer_seq: ACC_W too small for DATA_W/N_INPUTS");
  end

  nn_state_e state, state_nxt;

  logic signed [DATA_W-1:0] prm [N_SLOTS];
  logic signed [DATA_W-1:0] inp [N_INPUTS];
  logic [SW-1:0]            cfg_ptr, cfg_slot, nbase;
  logic [SW-1:0]            w_idx, th_idx, bias_idx;
  logic [KW-1:0]            k, in_ptr;
  logic [NW-1:0]            n;
  logic [DATA_W-1:0]        val [N_NEURONS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] th_cur;
  logic                     load_ok, start_acc, last_k, last_n;
  logic                     mac_load, mac_en, fire_now;
  logic [DATA_W-1:0]        val_now;

  assign load_ok   = (state == IDLE) || (state == DONE);
  assign start_acc = start && load_ok;
  assign last_k    = (k == KW'(N_INPUTS - 1));
  assign last_n    = (n == NW'(N_NEURONS - 1));
  assign busy      = (state == MAC) || (state == CMP);
  assign done      = (state == DONE);

  // Parameter addressing: nbase tracks the first slot of neuron n.
  assign cfg_slot = cfg_clear ? '0 : cfg_ptr;
  assign w_idx    = nbase + SW'(k);
  assign th_idx   = nbase + SW'(TH_OFS);
  // On a fresh start neuron 0's bias; from CMP the next neuron's bias.
  assign bias_idx = start_acc ? SW'(BIAS_OFS) : (nbase + SW'(SPN) + SW'(BIAS_OFS));
  assign th_cur   = prm[th_idx];
  assign fire_now = (acc >= ACC_W'(th_cur));

`ifdef NN_RELU_OUT_EN
  localparam logic signed [ACC_W:0] RELU_MAX = (ACC_W+1)'((2 ** (DATA_W - 1)) - 1);
  logic signed [ACC_W:0] diff;
  assign diff = (ACC_W+1)'(acc) - (ACC_W+1)'(th_cur);
  always_comb begin
    val_now = '0;
    if (diff > RELU_MAX) begin
      val_now = RELU_MAX[DATA_W-1:0];
    end else if (diff > 0) begin
      val_now = diff[DATA_W-1:0];
    end
  end
`else
  assign val_now = {{(DATA_W-1){1'b0}}, fire_now};
`endif

  nn_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .load     (mac_load),
    .load_val (prm[bias_idx]),
    .acc_en   (mac_en),
    .a        (inp[k]),
    .b        (prm[w_idx]),
    .acc      (acc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mac_load  = 1'b0;
    mac_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = MAC;
          mac_load  = 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (last_k) state_nxt = CMP;
      end
      CMP: begin
        if (last_n) begin
          state_nxt = DONE;
        end else begin
          state_nxt = MAC;
          mac_load  = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = MAC;
          mac_load  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer counters and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n         <= '0;
      k         <= '0;
      nbase     <= '0;
      out_fire  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) val[i] <= '0;
    end else begin
      if (start_acc) begin
        n         <= '0;
        k         <= '0;
        nbase     <= '0;
        out_valid <= 1'b0;
      end else if (state == MAC) begin
        k <= last_k ? '0 : k + KW'(1);
      end else if (state == CMP) begin
        out_fire[n] <= fire_now;
        val[n]      <= val_now;
        if (last_n) begin
          out_valid <= 1'b1;
        end else begin
          n     <= n + NW'(1);
          nbase <= nbase + SW'(SPN);
          k     <= '0;
        end
      end
    end
  end

  // Parameter / input stores and their pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_ptr <= '0;
      in_ptr  <= '0;
      cfg_err <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) prm[i] <= '0;
      for (int i = 0; i < N_INPUTS; i++) inp[i] <= '0;
    end else begin
      if (cfg_valid && load_ok) begin
        prm[cfg_slot] <= cfg_data;
        cfg_ptr       <= (cfg_slot == SW'(N_SLOTS - 1)) ? '0 : cfg_slot + SW'(1);
      end else if (cfg_clear) begin
        cfg_ptr <= '0;
      end
      if (in_valid && load_ok) begin
        inp[in_ptr] <= in_data;
        in_ptr      <= (in_ptr == KW'(N_INPUTS - 1)) ? '0 : in_ptr + KW'(1);
      end
      if ((cfg_valid || in_valid) && !load_ok) begin
        cfg_err <= 1'b1;
      end
    end
  end

  always_comb begin
    out_value = '0;
    if (int'(out_sel) < N_NEURONS) begin
      out_value = val[out_sel];
    end
  end

endmodule

// File: tb/tb_nn_layer_seq.sv
// Directed bench for nn_layer_seq at default parameters (4 neurons x 4 inputs).
module tb_nn_layer_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid, cfg_clear, in_valid, start;
  logic [7:0] cfg_data, in_data;
  logic       busy, done, out_valid, cfg_err;
  logic [3:0] out_fire;
  logic [1:0] out_sel;
  logic [7:0] out_value;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nn_layer_seq dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_clear (cfg_clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_fire  (out_fire),
    .out_sel   (out_sel),
    .out_value (out_value),
    .cfg_err   (cfg_err)
  );

  task automatic cfg_write(input logic [7:0] d, input logic clr);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_clear = clr;
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_clear = 1'b0;
  endtask

  task automatic load_neuron(input logic [7:0] w, input logic [7:0] b, input logic [7:0] th);
    for (int i = 0; i < 4; i++) cfg_write(w, 1'b0);
    cfg_write(b, 1'b0);
    cfg_write(th, 1'b0);
  endtask

  task automatic load_inputs(input logic [7:0] a0, input logic [7:0] a1,
                             input logic [7:0] a2, input logic [7:0] a3);
    logic [7:0] v [4];
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_basic();
    for (int i = 0; i < 4; i++) load_neuron(8'd1, 8'd0, 8'd10);
  endtask

  // Runs one evaluation over a fixed 40-cycle window. c counts edges since the
  // start-sampling edge. Optionally drives a cfg write or a second start mid-run.
  task automatic run_layer(input int inject_at, input int start_at,
                           output int first_done, output int ndone, output logic busy0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first_done = -1;
    ndone = 0;
    busy0 = busy;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = c;
      end
      cfg_valid = (c == inject_at);
      cfg_data  = 8'h80;
      start     = (c == start_at);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    cfg_valid = 1'($urandom);
    cfg_clear = 1'($urandom);
    cfg_data  = 8'($urandom);
    in_valid  = 1'($urandom);
    in_data   = 8'($urandom);
    start     = 1'($urandom);
    out_sel   = 2'($urandom);
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_fire !== 4'b0000) begin errors++; $display("FAIL reset_out_fire: got %b want 0000", out_fire); end
    checks++; if (out_value !== 8'h00) begin errors++; $display("FAIL reset_out_value: got %h want 00", out_value); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    cfg_valid = 0; cfg_clear = 0; cfg_data = 0; in_valid = 0; in_data = 0; start = 0; out_sel = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int fd, nd;
    logic b0;
    load_basic();
    load_inputs(8'd1, 8'd2, 8'd3, 8'd4);
    run_layer(-1, -1, fd, nd, b0);
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", b0); end
    checks++; if (fd !== 20) begin errors++; $display("FAIL basic_latency: got %0d want 20", fd); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", nd); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid_held: got %b want 1", out_valid); end
    checks++; if (out_fire !== 4'b1111) begin errors++; $display("FAIL basic_fire: got %b want 1111", out_fire); end
    out_sel = 2'd0; #1;
`ifdef NN_RELU_OUT_EN
    checks++; if (out_value !== 8'd0) begin errors++; $display("FAIL basic_value0: got %0d want 0", out_value); end
`else
    checks++; if (out_value !== 8'd1) begin errors++; $display("FAIL basic_value0: got %0d want 1", out_value); end
`endif
  endtask

  task automatic test_neg_weights();
    int fd, nd;
    logic b0;
    load_neuron(8'd1, 8'd0, 8'd10);
    load_neuron(8'd1, 8'd0, 8'd10);
    load_neuron(8'hFF, 8'd0, 8'd10);
    load_neuron(8'd1, 8'd0, 8'd10);
    run_layer(-1, -1, fd, nd, b0);
    checks++; if (out_fire !== 4'b1011) begin errors++; $display("FAIL neg_fire: got %b want 1011", out_fire); end
    out_sel = 2'd0; #1;
`ifdef NN_RELU_OUT_EN
    checks++; if (out_value !== 8'd0) begin errors++; $display("FAIL neg_value0: got %0d want 0", out_value); end
`else
    checks++; if (out_value !== 8'd1) begin errors++; $display("FAIL neg_value0: got %0d want 1", out_value); end
`endif
    out_sel = 2'd2; #1;
    checks++; if (out_value !== 8'd0) begin errors++; $display("FAIL neg_value2: got %0d want 0", out_value); end
  endtask

  task automatic test_extreme();
    int fd, nd;
    logic b0;
    // acc = 127 + 4*16384 = 65663, fits in 20 bits
    for (int i = 0; i < 4; i++) load_neuron(8'h80, 8'h7F, 8'h7F);
    load_inputs(8'h80, 8'h80, 8'h80, 8'h80);
    run_layer(-1, -1, fd, nd, b0);
    checks++; if (out_fire !== 4'b1111) begin errors++; $display("FAIL extreme_fire: got %b want 1111", out_fire); end
    out_sel = 2'd3; #1;
`ifdef NN_RELU_OUT_EN
    checks++; if (out_value !== 8'd127) begin errors++; $display("FAIL extreme_value: got %0d want 127", out_value); end
`else
    checks++; if (out_value !== 8'd1) begin errors++; $display("FAIL extreme_value: got %0d want 1", out_value); end
`endif
  endtask

  task automatic test_start_while_busy();
    int fd, nd;
    logic b0;
    load_basic();
    load_inputs(8'd1, 8'd2, 8'd3, 8'd4);
    run_layer(-1, 5, fd, nd, b0);
    checks++; if (nd !== 1) begin errors++; $display("FAIL busy_start_pulses: got %0d want 1", nd); end
    checks++; if (fd !== 20) begin errors++; $display("FAIL busy_start_latency: got %0d want 20", fd); end
  endtask

  task automatic test_cfg_while_busy();
    int fd, nd;
    logic b0;
    run_layer(10, -1, fd, nd, b0);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_set: got %b want 1", cfg_err); end
    // A write that slipped into w[0][0] (-128) would drop neuron 0 on a rerun.
    run_layer(-1, -1, fd, nd, b0);
    checks++; if (out_fire !== 4'b1111) begin errors++; $display("FAIL cfg_busy_params: got %b want 1111", out_fire); end
  endtask

  task automatic test_wrap();
    int fd, nd;
    logic b0;
    load_basic();
    cfg_write(8'h80, 1'b0);
    run_layer(-1, -1, fd, nd, b0);
    checks++; if (out_fire !== 4'b1110) begin errors++; $display("FAIL wrap_fire: got %b want 1110", out_fire); end
  endtask

  task automatic test_clear();
    int fd, nd;
    logic b0;
    // Neuron 0 becomes w=1,1,1,1 bias=-20 th=-10: acc=-10, fires only if the
    // clear write lands in slot 0 and the following writes start at slot 1.
    cfg_write(8'd1, 1'b1);
    cfg_write(8'd1, 1'b0);
    cfg_write(8'd1, 1'b0);
    cfg_write(8'd1, 1'b0);
    cfg_write(8'hEC, 1'b0);
    cfg_write(8'hF6, 1'b0);
    run_layer(-1, -1, fd, nd, b0);
    checks++; if (out_fire !== 4'b1111) begin errors++; $display("FAIL clear_fire: got %b want 1111", out_fire); end
  endtask

  task automatic test_reset_mid_run();
    int nd;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL midreset_done: got %0d want 0", nd); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
  endtask

  initial begin
    reset = 1'b1;
    cfg_valid = 0; cfg_clear = 0; cfg_data = 0;
    in_valid = 0; in_data = 0; start = 0; out_sel = 0;
    test_reset();
    test_basic();
    test_neg_weights();
    test_extreme();
    test_start_while_busy();
    test_cfg_while_busy();
    test_wrap();
    test_clear();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
